mult_seq_hs: RTL and testbench
==============================

// Module: mult_seq_hs
// PURPOSE
//  Parametrised sequential shift-add multiplier: WIDTH cycles per product, valid/ready on both sides.
//  Per-operation signed/unsigned mode; optional running accumulate.
//  Drop-in arithmetic engine for datapaths that need back-pressure rather than start/done pulses.
// PARAMETERS
//  WIDTH    8   operand width in bits, >= 2; product is 2*WIDTH
//  CNT_W    $clog2(WIDTH+1)   localparam, iteration counter width (not overridable)
// PORTS
//  clk          in   1        rising-edge clock
//  rst          in   1        asynchronous, active-high reset
//  in_valid     in   1        operand beat valid
//  in_ready     out  1        block can accept operands
//  a            in   WIDTH    multiplicand
//  b            in   WIDTH    multiplier
//  signed_mode  in   1        1: a,b two's complement; 0: unsigned (sampled with operands)
//  acc_clr      in   1        [MULT_ACC_EN only] 1: accumulator loads this product, 0: adds to it
//  out_valid    out  1        product valid
//  out_ready    in   1        consumer accepts product
//  product      out  2*WIDTH  result (accumulated sum when MULT_ACC_EN)
// BEHAVIOUR
//  Reset (async, any state): state=IDLE, in_ready=0, out_valid=0, product=0, accumulator=0, counter=0.
//  in_ready registered: 1 from the first clk edge after rst deasserts while in IDLE; 0 in CALC and DONE.
//  FSM: IDLE -> CALC on in_valid&&in_ready (edge T0): latch a, b, signed_mode (and acc_clr); cnt=0, partial=0.
//   CALC: one multiplier bit per cycle, LSB first. Step i adds (a extended to 2W, sign-ext if signed_mode else zero-ext) << i when b[i]=1.
//   Signed mode, i=WIDTH-1: shifted term is SUBTRACTED (two's-complement MSB weight). All arithmetic mod 2^(2W).
//   After WIDTH steps (edge T0+WIDTH): CALC -> DONE, product updated, out_valid=1 on that same edge.
//   DONE: product and out_valid held stable until out_valid&&out_ready; on that edge -> IDLE, out_valid=0, in_ready=1.
//  Latency: accept edge to out_valid = WIDTH cycles; min initiation interval = WIDTH+1 cycles (out_ready tied 1).
//  Operand/mode inputs changing during CALC/DONE have no effect; in_valid ignored outside IDLE.
//  out_ready asserted while out_valid=0: no effect. product retains last value in IDLE (not cleared).
//  Zero operand still takes full WIDTH cycles (no early termination).
//  Signed -2^(W-1) * -2^(W-1) = +2^(2W-2), representable in 2W bits, no overflow flag.
//  rst mid-CALC or mid-DONE: in-flight result discarded, no out_valid produced.
// CONFIGURATION
//  MULT_ACC_EN defined: acc_clr port present; 2W-bit accumulator. On CALC->DONE, accumulator <=
//   (acc_clr_latched ? p : accumulator + p) mod 2^(2W), where p is the current product;
//   product output shows the accumulator. Accumulator survives between operations; cleared only by rst or acc_clr.
//  MULT_ACC_EN undefined: no acc_clr port, no accumulator; product = a*b of last operation.
// TESTING
//  1. WIDTH=8, unsigned, a=255,b=255, out_ready=1 -> product=65025 (0xFE01), out_valid exactly 8 cycles after accept.
//  2. Signed: (-128)*(-128)=16384; (127)*(-128)=-16256 (0xC080); (-5)*3=-15 (0xFFF1); 0*-7=0 in full 8 cycles.
//  3. Back-pressure: out_ready=0 for 20 cycles after out_valid -> product/out_valid stable, in_ready=0 throughout;
//     release -> in_ready=1 next edge; new in_valid beat before release is not accepted.
//  4. Reset mid-CALC (cycle 4 of 8) -> out_valid stays 0, product=0, in_ready=0 then 1 one edge after rst drops; next op 6*7=42.
//  5. WIDTH=13 and WIDTH=2 instances: 500 random signed/unsigned pairs vs behavioural a*b; latency == WIDTH every time.
//  6. MULT_ACC_EN: ops (3*4,clr=1),(5*5,clr=0),(-2*10,clr=0 signed) -> products 12, 37, 17; then (1*1,clr=1) -> 1.

Source files
------------

// File: rtl/mult_seq_hs.sv
// Sequential shift-add multiplier, one multiplier bit per cycle, valid/ready on both sides.
// Define MULT_ACC_EN to add the acc_clr port and a running 2*WIDTH-bit accumulator on the output.
module mult_seq_hs #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               signed_mode,
`ifdef MULT_ACC_EN
  input  logic               acc_clr,
`endif
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product
);

  localparam int PW    = 2 * WIDTH;
  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t                state_q, state_d;
  logic                  in_ready_q, in_ready_d;
  logic                  out_valid_q, out_valid_d;
  logic signed [PW-1:0]  product_q, product_d;
  logic signed [PW-1:0]  partial_q, partial_d;
  logic signed [PW-1:0]  mcand_q, mcand_d;
  logic [WIDTH-1:0]      mplier_q, mplier_d;
  logic                  sm_q, sm_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
`ifdef MULT_ACC_EN
  logic                  clr_q, clr_d;
`endif

  logic                  last_step;
  logic signed [PW-1:0]  step_sum;

  // The multiplicand is pre-shifted each cycle, so step i only ever looks at bit 0 of the
  // right-shifting multiplier; the final signed step carries negative weight.
  always_comb begin
    last_step = (cnt_q == CNT_W'(WIDTH - 1));
    step_sum  = partial_q;
    if (mplier_q[0]) begin
      if (sm_q && last_step) step_sum = partial_q - mcand_q;
      else                   step_sum = partial_q + mcand_q;
    end
  end

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    product_d   = product_q;
    partial_d   = partial_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    sm_d        = sm_q;
    cnt_d       = cnt_q;
`ifdef MULT_ACC_EN
    clr_d       = clr_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          state_d   = CALC;
          mcand_d   = signed_mode ? {{WIDTH{a[WIDTH-1]}}, a} : {{WIDTH{1'b0}}, a};
          mplier_d  = b;
          sm_d      = signed_mode;
          cnt_d     = '0;
          partial_d = '0;
`ifdef MULT_ACC_EN
          clr_d     = acc_clr;
`endif
        end
      end
      CALC: begin
        partial_d = step_sum;
        mcand_d   = mcand_q <<< 1;
        mplier_d  = mplier_q >> 1;
        cnt_d     = cnt_q + CNT_W'(1);
        if (last_step) begin
          state_d     = DONE;
          out_valid_d = 1'b1;
`ifdef MULT_ACC_EN
          product_d   = clr_q ? step_sum : product_q + step_sum;
`else
          product_d   = step_sum;
`endif
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
    // in_ready is a registered view of "next state is IDLE", so it rises one edge after reset
    in_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      product_q   <= '0;
      partial_q   <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      sm_q        <= 1'b0;
      cnt_q       <= '0;
`ifdef MULT_ACC_EN
      clr_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      product_q   <= product_d;
      partial_q   <= partial_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      sm_q        <= sm_d;
      cnt_q       <= cnt_d;
`ifdef MULT_ACC_EN
      clr_q       <= clr_d;
`endif
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign product   = product_q;

endmodule

// File: tb/tb_mult_seq_hs.sv
// Scoreboard bench for mult_seq_hs: WIDTH=8 directed/random instance plus WIDTH=13 and WIDTH=2 random instances.
module tb_mult_seq_hs;
  localparam int W  = 8;
  localparam int PW = 2 * W;

  typedef struct {
    longint exp;
    int     t;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, rst_g;
  logic          in_valid, in_ready, sm, clr, out_valid, out_ready;
  logic [W-1:0]  a, b;
  logic [PW-1:0] product;

  int     checks = 0;
  int     errors = 0;
  int     cyc = 0;
  exp_t   sb[$];
  longint acc_m;
  bit     prev_v;
  int     vcyc;
  bit     tog_run;

  always @(posedge clk) cyc <= cyc + 1;

  mult_seq_hs #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .signed_mode(sm),
`ifdef MULT_ACC_EN
    .acc_clr(clr),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .product(product)
  );

  function automatic longint mask(int w);
    return (longint'(1) << (2 * w)) - 1;
  endfunction

  // Reference: plain integer multiply of the interpreted operands, reduced mod 2^(2w)
  function automatic longint model(longint ma, longint mb, bit msm, int w);
    longint va = ma;
    longint vb = mb;
    if (msm) begin
      if (((ma >> (w - 1)) & 1) != 0) va = ma - (longint'(1) << w);
      if (((mb >> (w - 1)) & 1) != 0) vb = mb - (longint'(1) << w);
    end
    return (va * vb) & mask(w);
  endfunction

  function automatic longint accum(longint p, bit c, longint acc, int w);
`ifdef MULT_ACC_EN
    return c ? p : ((acc + p) & mask(w));
`else
    return (p | (acc & 0)) & mask(w) & {64{c | ~c}};
`endif
  endfunction

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Monitor for the WIDTH=8 instance
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      prev_v = 1'b0;
    end else begin
      if (out_valid && !prev_v) vcyc = cyc;
      if (out_valid) chk("w8_in_ready_low_while_valid", in_ready, 0);
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL w8_unexpected_output: product 0x%0h, nothing outstanding", product);
        end else begin
          e = sb.pop_front();
          chk("w8_product", longint'(product), e.exp);
          chk("w8_latency", longint'(vcyc - e.t), W);
        end
      end
      prev_v = out_valid;
    end
  end

  // Called at a negedge; returns at the negedge after the accept edge
  task automatic issue(input logic [W-1:0] ta, input logic [W-1:0] tb_, input bit tsm, input bit tclr);
    exp_t e;
    int   n = 0;
    a = ta; b = tb_; sm = tsm; clr = tclr; in_valid = 1'b1;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL w8_accept_timeout: in_ready 0, expected 1 within 200 cycles");
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    e.t   = cyc + 1;
    acc_m = accum(model(longint'(ta), longint'(tb_), tsm, W), tclr, acc_m, W);
    e.exp = acc_m;
    sb.push_back(e);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL w8_drain_timeout: %0d outstanding, expected 0", sb.size());
      sb.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    rst_g = 1'b1;
    repeat (3) @(negedge clk);
    rst_g = 1'b0;
  end

  // Extra widths, random operands, out_ready held high
  for (genvar g = 0; g < 2; g++) begin : gw
    localparam int WS = (g == 0) ? 13 : 2;
    logic            iv, ir, gsm, gclr, ov, gr;
    logic [WS-1:0]   ga, gb;
    logic [2*WS-1:0] gp;
    exp_t            q[$];
    longint          gacc;
    bit              pv;
    int              vc;
    bit              done = 1'b0;
    exp_t            ge;

    mult_seq_hs #(.WIDTH(WS)) u (
      .clk(clk), .rst(rst_g), .in_valid(iv), .in_ready(ir),
      .a(ga), .b(gb), .signed_mode(gsm),
`ifdef MULT_ACC_EN
      .acc_clr(gclr),
`endif
      .out_valid(ov), .out_ready(gr), .product(gp)
    );

    always @(negedge clk) begin
      if (rst_g) begin
        pv = 1'b0;
      end else begin
        if (ov && !pv) vc = cyc;
        if (ov && gr) begin
          if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL w%0d_unexpected_output: product 0x%0h, nothing outstanding", WS, gp);
          end else begin
            ge = q.pop_front();
            chk($sformatf("w%0d_product", WS), longint'(gp), ge.exp);
            chk($sformatf("w%0d_latency", WS), longint'(vc - ge.t), WS);
          end
        end
        pv = ov;
      end
    end

    initial begin
      exp_t e;
      int   n;
      iv = 1'b0; ga = '0; gb = '0; gsm = 1'b0; gclr = 1'b0; gr = 1'b1; gacc = 0;
      @(negedge clk);
      while (rst_g) @(negedge clk);
      @(negedge clk);
      for (int k = 0; k < 500; k++) begin
        ga   = WS'($urandom);
        gb   = WS'($urandom);
        gsm  = $urandom_range(0, 1) != 0;
        gclr = $urandom_range(0, 3) == 0;
        iv   = 1'b1;
        n    = 0;
        while (!ir && n < 200) begin
          @(negedge clk);
          n++;
        end
        if (!ir) begin
          checks++;
          errors++;
          $display("FAIL w%0d_accept_timeout: in_ready 0, expected 1", WS);
          break;
        end
        @(posedge clk);
        e.t   = cyc + 1;
        gacc  = accum(model(longint'(ga), longint'(gb), gsm, WS), gclr, gacc, WS);
        e.exp = gacc;
        q.push_back(e);
        @(negedge clk);
        iv = 1'b0;
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      n = 0;
      while (q.size() != 0 && n < 2000) begin
        @(negedge clk);
        n++;
      end
      if (q.size() != 0) begin
        checks++;
        errors++;
        $display("FAIL w%0d_drain_timeout: %0d outstanding, expected 0", WS, q.size());
      end
      done = 1'b1;
    end
  end

  initial begin
    logic [PW-1:0] held;
    int            n;
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; sm = 1'b0; clr = 1'b0;
    out_ready = 1'b1; acc_m = 0; tog_run = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_in_ready", in_ready, 0);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_product", longint'(product), 0);
    rst = 1'b0;
    #1 chk("in_ready_before_first_edge", in_ready, 0);
    @(negedge clk);
    chk("in_ready_after_first_edge", in_ready, 1);

    // Directed products (each clears any accumulator)
    issue(8'd255, 8'd255, 1'b0, 1'b1);
    issue(8'h80, 8'h80, 1'b1, 1'b1);
    issue(8'd127, 8'h80, 1'b1, 1'b1);
    issue(8'hFB, 8'd3, 1'b1, 1'b1);
    issue(8'd0, 8'hF9, 1'b1, 1'b1);
    drain();

    // Accumulate sequence: 12, 37, 17, then 1
    issue(8'd3, 8'd4, 1'b0, 1'b1);
    issue(8'd5, 8'd5, 1'b0, 1'b0);
    issue(8'hFE, 8'd10, 1'b1, 1'b0);
    issue(8'd1, 8'd1, 1'b0, 1'b1);
    drain();

    // Back-pressure with a competing operand beat held during DONE
    out_ready = 1'b0;
    issue(8'd200, 8'd3, 1'b0, 1'b1);
    n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("bp_out_valid_seen", out_valid, 1);
    held = product;
    a = 8'd9; b = 8'd9; sm = 1'b0; clr = 1'b1; in_valid = 1'b1;
    repeat (20) begin
      @(negedge clk);
      chk("bp_out_valid_held", out_valid, 1);
      chk("bp_product_held", longint'(product), longint'(held));
      chk("bp_in_ready_low", in_ready, 0);
    end
    in_valid = 1'b0;
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_in_ready_after_release", in_ready, 1);
    chk("bp_out_valid_after_release", out_valid, 0);
    chk("bp_product_retained_in_idle", longint'(product), longint'(held));
    drain();

    // Reset in the middle of CALC
    issue(8'd100, 8'd100, 1'b0, 1'b1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    sb.delete();
    acc_m = 0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_product", longint'(product), 0);
    chk("midrst_in_ready", in_ready, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1 chk("midrst_in_ready_before_edge", in_ready, 0);
    @(negedge clk);
    chk("midrst_in_ready_after_edge", in_ready, 1);
    repeat (10) begin
      @(negedge clk);
      chk("midrst_no_stale_output", out_valid, 0);
    end
    issue(8'd6, 8'd7, 1'b0, 1'b1);
    drain();

    // Random traffic with random back-pressure
    tog_run = 1'b1;
    fork
      begin
        while (tog_run) begin
          @(posedge clk);
          #1 out_ready = $urandom_range(0, 3) != 0;
        end
      end
    join_none
    for (int k = 0; k < 300; k++) begin
      issue(W'($urandom), W'($urandom), $urandom_range(0, 1) != 0, $urandom_range(0, 3) == 0);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    tog_run = 1'b0;
    @(posedge clk);
    #2 out_ready = 1'b1;
    drain();

    n = 0;
    while (!(gw[0].done && gw[1].done) && n < 20000) begin
      @(negedge clk);
      n++;
    end
    if (!(gw[0].done && gw[1].done)) begin
      checks++;
      errors++;
      $display("FAIL wide_narrow_timeout: instances not finished, expected done");
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
